// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with next-PC select for the 5-stage MIPS pipeline.
// Optional range/alignment checking is enabled by defining FETCH_PC_CHECK_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] D_PC,
    input  logic [1:0]  D_npc_sel,
    input  logic        D_br_taken,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_instr_index,
    input  logic [31:0] D_rs_fwd,
    output logic [31:0] F_PC,
    output logic [31:0] F_PC8,
    output logic [31:0] F_fetch_cnt,
    output logic        F_fetch_err
);

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_J   = 2'b10;
    localparam logic [1:0] SEL_JR  = 2'b11;

    logic [31:0] pc_q;
    logic [31:0] cnt_q;
    logic [31:0] f_pc4;
    logic [31:0] d_pc4;
    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] npc;

    assign f_pc4  = pc_q + 32'd4;
    assign F_PC8  = pc_q + 32'd8;
    assign d_pc4  = D_PC + 32'd4;
    assign br_off = {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign br_tgt = d_pc4 + br_off;
    assign j_tgt  = {d_pc4[31:28], D_instr_index, 2'b00};

    always_comb begin
        npc = f_pc4;
        unique case (D_npc_sel)
            SEL_SEQ: npc = f_pc4;
            SEL_BR:  npc = D_br_taken ? br_tgt : f_pc4;
            SEL_J:   npc = j_tgt;
            SEL_JR:  npc = D_rs_fwd;
            default: npc = f_pc4;
        endcase
    end

    // Stall freezes both the PC and the advance counter; D re-presents
    // any redirect once the stall clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= 32'd0;
        end else if (!stall) begin
            pc_q  <= npc;
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign F_PC        = pc_q;
    assign F_fetch_cnt = cnt_q;

`ifdef FETCH_PC_CHECK_EN
    logic npc_bad;
    logic err_q;

    assign npc_bad = (npc[1:0] != 2'b00) || (npc < TEXT_LO) || (npc > TEXT_HI);

    // The offending PC is still loaded; the flag only records it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (!stall && npc_bad) begin
            err_q <= 1'b1;
        end
    end

    assign F_fetch_err = err_q;
`else
    localparam logic RANGE_SANE = (TEXT_LO <= TEXT_HI);

    assign F_fetch_err = 1'b0 & RANGE_SANE;
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage program counter for the 5-stage MIPS pipeline; sits on the receiving side of the sequential-increment path.
- Holds the architectural F-stage PC and computes its own sequential successor (PC+4).
- Selects the next PC among sequential, branch, jump and jump-register targets resolved in D, honouring pipeline stalls.
- Drives the instruction-memory address and the PC carried into the F/D pipeline register; delayed-branch semantics (one delay slot).

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address (optional feature only).
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds PC when 1.
- D_PC  in  32  PC of the instruction currently in D (branch/jump owner).
- D_npc_sel  in  2  00 sequential, 01 branch, 10 j/jal, 11 jr/jalr.
- D_br_taken  in  1  branch comparison result from D; used only when D_npc_sel=01.
- D_imm16  in  16  branch offset field.
- D_instr_index  in  26  j/jal target field.
- D_rs_fwd  in  32  forwarded rs value (jr/jalr target).
- F_PC  out  32  current fetch address to IM and F/D register.
- F_PC8  out  32  F_PC+8 (link value support).
- F_fetch_cnt  out  32  count of cycles in which PC advanced.
- F_fetch_err  out  1  sticky range/alignment error (optional feature; else constant 0).

Behaviour:
- Reset (clk edge with reset=1): F_PC=RESET_PC, F_fetch_cnt=0, F_fetch_err=0. Reset dominates stall and every select input.
- Internal: F_PC4 = F_PC + 32'd4, modulo 2^32 (wraps 0xFFFFFFFC -> 0x00000000, no flag). F_PC8 = F_PC + 8, combinational, same wrap.
- D_PC4 = D_PC + 4. Branch target = D_PC4 + {{14{D_imm16[15]}}, D_imm16, 2'b00}, modulo 2^32.
- Jump target = {D_PC4[31:28], D_instr_index, 2'b00}. JR target = D_rs_fwd, used unmodified.
- NPC selection (combinational):
  - 00 -> F_PC4.
  - 01 -> branch target if D_br_taken else F_PC4.
  - 10 -> jump target.
  - 11 -> jr target.
- Delay slot is implicit: the redirect is issued while the slot instruction is in F, so it still reaches D.
- Update rule, each rising edge with reset=0:
  - stall=1 -> F_PC and F_fetch_cnt hold; D_* inputs are ignored, since D holds and the redirect is re-presented next cycle.
  - stall=0 -> F_PC <= NPC; F_fetch_cnt <= F_fetch_cnt + 1 (wraps at 2^32).
- Latency: a redirect presented in cycle n is visible on F_PC in cycle n+1.
- No internal pending-redirect state; stall and redirect in the same cycle result in hold.
- Reset asserted mid-stall or mid-redirect: next edge loads RESET_PC and discards the redirect.
- Undefined select values: none; all four encodings are defined.

Optional Feature:
- Macro FETCH_PC_CHECK_EN.
- Defined:
  - On each non-stalled, non-reset edge, if NPC[1:0]!=0, or NPC<TEXT_LO, or NPC>TEXT_HI, F_fetch_err is set to 1 and stays 1 until reset.
  - The PC still loads the offending NPC; there is no trap.
- Undefined: F_fetch_err is tied to 0 and the range/alignment logic is not synthesised.

Test Plan:
- Reset, then 3 unstalled cycles with D_npc_sel=00 -> F_PC 0x3000, 0x3004, 0x3008, 0x300C; F_fetch_cnt=3; F_PC8=0x3014 at the end.
- F_PC=0x3010, stall=1 for 2 cycles with D_npc_sel=10 driven -> F_PC stays 0x3010 and cnt is unchanged; stall=0, D_PC=0x300C, D_instr_index=26'h0000C10 -> F_PC=0x3040.
- D_npc_sel=01, D_PC=0x3020, D_imm16=16'hFFFC, D_br_taken=1 -> F_PC=0x3014; same inputs with D_br_taken=0 and F_PC=0x3024 -> F_PC=0x3028.
- D_npc_sel=11, D_rs_fwd=0x0000_3100 -> F_PC=0x3100; then reset asserted together with D_npc_sel=11 -> F_PC=0x3000, cnt=0.
- Force F_PC to 0xFFFFFFFC via jr, then sequential -> F_PC=0x00000000; F_PC8 at 0xFFFFFFFC equals 0x00000004.
- With FETCH_PC_CHECK_EN: jr to 0x3002 -> F_fetch_err=1 and it stays 1 after legal fetches until reset; without the macro, F_fetch_err stays 0.
